// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register pending scoreboard,
// bypassed combinational reads and a one-register-per-cycle clear sweep.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   SrcReg1/2 -> SrcData1/2         combinational read ports
//   SrcPending1/2                   outstanding producer on read register
//   WriteReg, DstReg, DstData       synchronous write (clears pending)
//   Reserve, ReserveReg             mark register pending
//   ClearReq -> Busy                start clear sweep / sweep in progress
module reg_file_sb #(
   parameter int  WIDTH    = 16,
   parameter int  DEPTH    = 16,
   parameter int  ZERO_REG = 1,
   parameter int  BYPASS   = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    SrcReg1,
   input  logic [AW-1:0]    SrcReg2,
   output logic [WIDTH-1:0] SrcData1,
   output logic [WIDTH-1:0] SrcData2,
   output logic             SrcPending1,
   output logic             SrcPending2,
   input  logic             WriteReg,
   input  logic [AW-1:0]    DstReg,
   input  logic [WIDTH-1:0] DstData,
   input  logic             Reserve,
   input  logic [AW-1:0]    ReserveReg,
   input  logic             ClearReq,
   output logic             Busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] pending;
   logic [AW-1:0]    clr_idx;
   logic             busy_q;
   logic             wr_ok;
   logic             rsv_ok;

   assign Busy = busy_q;

   // Register 0 swallows writes and reservations when hardwired.
   assign wr_ok  = WriteReg &&
                   !((ZERO_REG != 0) && (DstReg == '0));
   assign rsv_ok = Reserve &&
                   !((ZERO_REG != 0) && (ReserveReg == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         pending <= '0;
         state   <= IDLE;
         clr_idx <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (wr_ok) begin
                  mem[DstReg]     <= DstData;
                  pending[DstReg] <= 1'b0;
               end
               // Later assignment wins: a new producer
               // reserving the register keeps it pending.
               if (rsv_ok) pending[ReserveReg] <= 1'b1;
               if (ClearReq) begin
                  state   <= CLEAR;
                  busy_q  <= 1'b1;
                  clr_idx <= '0;
               end
            end
            CLEAR: begin
               mem[clr_idx]     <= '0;
               pending[clr_idx] <= 1'b0;
               if (clr_idx == AW'(DEPTH - 1)) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  clr_idx <= '0;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
         endcase
      end
   end

   // Returns {pending, data} for one read port.
   function automatic logic [WIDTH:0] rd(input logic [AW-1:0] a);
      logic [WIDTH:0] r;
      r = {pending[a], mem[a]};
      if (rst || busy_q)
         r = '0;
      else if ((ZERO_REG != 0) && (a == '0))
         r = '0;
      else if ((BYPASS != 0) && WriteReg && (DstReg == a))
         r = {1'b0, DstData};
      return r;
   endfunction

   assign {SrcPending1, SrcData1} = rd(SrcReg1);
   assign {SrcPending2, SrcData2} = rd(SrcReg2);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb, default instance
// plus a BYPASS=0 / ZERO_REG=0 instance sharing the same stimulus.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  SrcReg1, SrcReg2, DstReg, ReserveReg;
   logic        WriteReg, Reserve, ClearReq;
   logic [15:0] DstData;
   logic [15:0] d1a, d2a, d1b, d2b;
   logic        p1a, p2a, p1b, p2b, busya, busyb;

   typedef struct {
      string       tag;
      logic [16:0] exp;
   } item_t;

   item_t       sb[$];
   item_t       it;
   logic [16:0] obs;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   reg_file_sb dut_a (
      .clk(clk), .rst(rst),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .SrcData1(d1a), .SrcData2(d2a),
      .SrcPending1(p1a), .SrcPending2(p2a),
      .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
      .Reserve(Reserve), .ReserveReg(ReserveReg),
      .ClearReq(ClearReq), .Busy(busya)
   );

   reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .SrcData1(d1b), .SrcData2(d2b),
      .SrcPending1(p1b), .SrcPending2(p2b),
      .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
      .Reserve(Reserve), .ReserveReg(ReserveReg),
      .ClearReq(ClearReq), .Busy(busyb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      WriteReg = 0; Reserve = 0; ClearReq = 0;
      DstReg = 0; DstData = 0; ReserveReg = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      SrcReg1 = 3; SrcReg2 = 0;
      tick();
      WriteReg = 1; DstReg = 3; DstData = 16'h1234;
      sb.push_back('{"rst_read", 17'h0});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      total++;
      if (busya !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy got=%b want=0", busya);
      end
      tick();
      rst = 0; idle_inputs();
      tick();
      WriteReg = 1; DstReg = 5; DstData = 16'hBEEF;
      tick();
      idle_inputs();
      SrcReg1 = 5; SrcReg2 = 5;
      sb.push_back('{"wr_r5_p1", {1'b0, 16'hBEEF}});
      sb.push_back('{"wr_r5_p2", {1'b0, 16'hBEEF}});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      obs = {p2a, d2a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
   endtask

   task automatic test_bypass();
      tick();
      WriteReg = 1; DstReg = 3; DstData = 16'h1234;
      SrcReg1 = 3;
      sb.push_back('{"byp_on", {1'b0, 16'h1234}});
      sb.push_back('{"byp_off", 17'h0});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      obs = {p1b, d1b};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      tick();
      idle_inputs();
      sb.push_back('{"byp_off_after", {1'b0, 16'h1234}});
      #3;
      obs = {p1b, d1b};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
   endtask

   task automatic test_scoreboard();
      tick();
      Reserve = 1; ReserveReg = 7;
      tick();
      idle_inputs();
      SrcReg2 = 7;
      sb.push_back('{"rsv_r7", {1'b1, 16'h0}});
      #3;
      obs = {p2a, d2a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      tick();
      WriteReg = 1; DstReg = 7; DstData = 16'h00AA;
      tick();
      idle_inputs();
      sb.push_back('{"wr_r7_clr", {1'b0, 16'h00AA}});
      #3;
      obs = {p2a, d2a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      tick();
      WriteReg = 1; DstReg = 7; DstData = 16'h00AA;
      Reserve = 1; ReserveReg = 7;
      tick();
      idle_inputs();
      sb.push_back('{"wr_rsv_a", {1'b1, 16'h00AA}});
      sb.push_back('{"wr_rsv_b", {1'b1, 16'h00AA}});
      #3;
      obs = {p2a, d2a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      obs = {p2b, d2b};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
   endtask

   task automatic test_zero_reg();
      tick();
      WriteReg = 1; DstReg = 0; DstData = 16'hFFFF;
      Reserve = 1; ReserveReg = 0;
      tick();
      idle_inputs();
      SrcReg1 = 0;
      sb.push_back('{"zero_on", 17'h0});
      sb.push_back('{"zero_off", {1'b1, 16'hFFFF}});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      obs = {p1b, d1b};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
   endtask

   task automatic test_clear();
      int cnt;
      for (int i = 0; i < 16; i++) begin
         tick();
         WriteReg = 1; DstReg = 4'(i); DstData = 16'h1000 + 16'(i);
      end
      tick();
      idle_inputs();
      Reserve = 1; ReserveReg = 9;
      tick();
      idle_inputs();
      SrcReg1 = 9;
      sb.push_back('{"fill_r9", {1'b1, 16'h1009}});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      tick();
      ClearReq = 1;
      tick();
      ClearReq = 0;
      cnt = 0;
      while (busya === 1'b1 && cnt < 40) begin
         cnt++;
         WriteReg = (cnt == 10);
         DstReg = 2; DstData = 16'h5555;
         ClearReq = (cnt == 5);
         tick();
      end
      idle_inputs();
      total++;
      if (cnt !== 16) begin
         bad++;
         $display("FAIL busy_len got=%0d want=16", cnt);
      end
      // First cycle with Busy low: write must land.
      WriteReg = 1; DstReg = 4; DstData = 16'hABCD;
      tick();
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         SrcReg1 = 4'(i);
         sb.push_back('{$sformatf("clr_a_r%0d", i),
                        (i == 4) ? {1'b0, 16'hABCD} : 17'h0});
         sb.push_back('{$sformatf("clr_b_r%0d", i),
                        (i == 4) ? {1'b0, 16'hABCD} : 17'h0});
         #1;
         obs = {p1a, d1a};
         it = sb.pop_front(); total++;
         if (obs !== it.exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
         end
         obs = {p1b, d1b};
         it = sb.pop_front(); total++;
         if (obs !== it.exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      tick();
      WriteReg = 1; DstReg = 12; DstData = 16'h7777;
      tick();
      idle_inputs();
      ClearReq = 1;
      tick();
      ClearReq = 0;
      repeat (4) tick();
      #2 rst = 1;
      #1;
      SrcReg1 = 12;
      #1;
      total++;
      if (busya !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_busy got=%b want=0", busya);
      end
      rst = 0;
      sb.push_back('{"mid_rst_r12", 17'h0});
      #1;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
      WriteReg = 1; DstReg = 1; DstData = 16'h0042;
      tick();
      idle_inputs();
      SrcReg1 = 1;
      sb.push_back('{"post_rst_r1", {1'b0, 16'h0042}});
      #3;
      obs = {p1a, d1a};
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_scoreboard();
      test_zero_reg();
      test_clear();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
